// File: rtl/rcc_osc_rdy_ctrl.sv
// Oscillator enable/ready sequencer for HSI, CSI and HSE, including the HSE CSS fail latch.
// Optional ready-flag interrupt logic is built when RCC_OSC_RDY_IRQ_EN is defined.
module rcc_osc_rdy_ctrl #(
  parameter int unsigned HSI_STARTUP_CYC = 64,
  parameter int unsigned CSI_STARTUP_CYC = 32,
  parameter int unsigned HSE_STARTUP_CYC = 2048,
  parameter int unsigned OFF_CYC         = 4,
  parameter int unsigned CNT_W           = 12
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       hsion,
  input  logic       csion,
  input  logic       hseon,
  input  logic [1:0] sys_clk_sw,
  input  logic       rcc_sys_stop,
  input  logic       hsi_ker_clk_req,
  input  logic       csi_ker_clk_req,
  input  logic       hse_css_evt,
  input  logic       hsecss_clr,
  output logic       hsi_en,
  output logic       csi_en,
  output logic       hse_en,
  output logic       hsi_rdy,
  output logic       csi_rdy,
  output logic       hse_rdy,
  output logic       hsecss_fail
`ifdef RCC_OSC_RDY_IRQ_EN
  ,
  input  logic [2:0] rdyie,
  input  logic [2:0] rdyc,
  output logic [2:0] rdyf,
  output logic       rcc_osc_irq
`endif
);

  localparam int unsigned NUM_OSC = 3;

  typedef enum logic [1:0] {
    ST_OFF      = 2'd0,
    ST_STARTUP  = 2'd1,
    ST_RDY      = 2'd2,
    ST_SHUTDOWN = 2'd3
  } osc_state_e;

  logic                sw_hsi_c;
  logic                sw_csi_c;
  logic                sw_hse_c;
  logic [NUM_OSC-1:0]  req_c;
  logic [NUM_OSC-1:0]  kill_c;
  logic [NUM_OSC-1:0]  en_w;
  logic [NUM_OSC-1:0]  rdy_w;
  logic                hsecss_fail_q;
  logic                hsecss_fail_d;

  assign sw_hsi_c = (sys_clk_sw == 2'b00);
  assign sw_csi_c = (sys_clk_sw == 2'b01);
  assign sw_hse_c = (sys_clk_sw == 2'b10);

  // Kernel requests keep HSI/CSI alive through stop; HSE is masked by a latched CSS failure.
  assign req_c[0] = ((hsion | sw_hsi_c) & ~rcc_sys_stop) | hsi_ker_clk_req;
  assign req_c[1] = ((csion | sw_csi_c) & ~rcc_sys_stop) | csi_ker_clk_req;
  assign req_c[2] = (hseon | sw_hse_c) & ~rcc_sys_stop & ~hsecss_fail_q;

  assign kill_c = {hse_css_evt, 2'b00};

  // CSS fail latch: a same-cycle event beats the clear.
  assign hsecss_fail_d = hse_css_evt | (hsecss_fail_q & ~hsecss_clr);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      hsecss_fail_q <= 1'b0;
    end else begin
      hsecss_fail_q <= hsecss_fail_d;
    end
  end

  for (genvar i = 0; i < NUM_OSC; i++) begin : g_osc
    localparam int unsigned STARTUP_CYC = (i == 0) ? HSI_STARTUP_CYC :
                                          (i == 1) ? CSI_STARTUP_CYC : HSE_STARTUP_CYC;

    osc_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             en_q;
    logic             rdy_q;

    // Per-oscillator sequencer; en/rdy are registered alongside the state they decode.
    always_ff @(posedge sys_clk) begin
      if (sys_rst || kill_c[i]) begin
        state_q <= ST_OFF;
        cnt_q   <= '0;
        en_q    <= 1'b0;
        rdy_q   <= 1'b0;
      end else begin
        unique case (state_q)
          ST_OFF: begin
            if (req_c[i]) begin
              state_q <= ST_STARTUP;
              cnt_q   <= '0;
              en_q    <= 1'b1;
            end
          end
          ST_STARTUP: begin
            if (!req_c[i]) begin
              state_q <= ST_OFF;
              cnt_q   <= '0;
              en_q    <= 1'b0;
            end else if (cnt_q == CNT_W'(STARTUP_CYC - 1)) begin
              state_q <= ST_RDY;
              cnt_q   <= '0;
              rdy_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_RDY: begin
            if (!req_c[i]) begin
              state_q <= ST_SHUTDOWN;
              cnt_q   <= '0;
              en_q    <= 1'b0;
            end
          end
          ST_SHUTDOWN: begin
            // Requests are ignored until OFF so the analog side always sees a full off period.
            if (cnt_q == CNT_W'(OFF_CYC - 1)) begin
              state_q <= ST_OFF;
              cnt_q   <= '0;
              rdy_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            rdy_q   <= 1'b0;
          end
        endcase
      end
    end

    assign en_w[i]  = en_q;
    assign rdy_w[i] = rdy_q;
  end

  assign hsi_en      = en_w[0];
  assign csi_en      = en_w[1];
  assign hse_en      = en_w[2];
  assign hsi_rdy     = rdy_w[0];
  assign csi_rdy     = rdy_w[1];
  assign hse_rdy     = rdy_w[2];
  assign hsecss_fail = hsecss_fail_q;

`ifdef RCC_OSC_RDY_IRQ_EN
  logic [NUM_OSC-1:0] rdy_prev_q;
  logic [NUM_OSC-1:0] rdyf_q;
  logic               irq_q;

  // Ready flags catch rising rdy edges; a new edge wins over a same-cycle clear.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rdy_prev_q <= '0;
      rdyf_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      rdy_prev_q <= rdy_w;
      rdyf_q     <= (rdyf_q & ~rdyc) | (rdy_w & ~rdy_prev_q);
      irq_q      <= |(rdyf_q & rdyie);
    end
  end

  assign rdyf        = rdyf_q;
  assign rcc_osc_irq = irq_q;
`endif

endmodule

// File: tb/tb_rcc_osc_rdy_ctrl.sv
// Scoreboard bench for rcc_osc_rdy_ctrl: expected per-cycle output values are queued
// when stimulus is applied and compared on the falling edge of the matching cycle.
module tb_rcc_osc_rdy_ctrl;

  localparam int S_HSI_EN  = 0;
  localparam int S_HSI_RDY = 1;
  localparam int S_CSI_EN  = 2;
  localparam int S_CSI_RDY = 3;
  localparam int S_HSE_EN  = 4;
  localparam int S_HSE_RDY = 5;
  localparam int S_FAIL    = 6;
  localparam int S_RDYF0   = 7;
  localparam int S_IRQ     = 8;

  logic       sys_clk;
  logic       sys_rst;
  logic       hsion, csion, hseon;
  logic [1:0] sys_clk_sw;
  logic       rcc_sys_stop;
  logic       hsi_ker_clk_req, csi_ker_clk_req;
  logic       hse_css_evt, hsecss_clr;
  logic       hsi_en, csi_en, hse_en;
  logic       hsi_rdy, csi_rdy, hse_rdy;
  logic       hsecss_fail;
`ifdef RCC_OSC_RDY_IRQ_EN
  logic [2:0] rdyie, rdyc, rdyf;
  logic       rcc_osc_irq;
`endif

  rcc_osc_rdy_ctrl dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .hsion           (hsion),
    .csion           (csion),
    .hseon           (hseon),
    .sys_clk_sw      (sys_clk_sw),
    .rcc_sys_stop    (rcc_sys_stop),
    .hsi_ker_clk_req (hsi_ker_clk_req),
    .csi_ker_clk_req (csi_ker_clk_req),
    .hse_css_evt     (hse_css_evt),
    .hsecss_clr      (hsecss_clr),
    .hsi_en          (hsi_en),
    .csi_en          (csi_en),
    .hse_en          (hse_en),
    .hsi_rdy         (hsi_rdy),
    .csi_rdy         (csi_rdy),
    .hse_rdy         (hse_rdy),
    .hsecss_fail     (hsecss_fail)
`ifdef RCC_OSC_RDY_IRQ_EN
    ,
    .rdyie           (rdyie),
    .rdyc            (rdyc),
    .rdyf            (rdyf),
    .rcc_osc_irq     (rcc_osc_irq)
`endif
  );

  typedef struct {
    int   cyc;
    int   sig;
    logic val;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [8:0] obs_c;

`ifdef RCC_OSC_RDY_IRQ_EN
  assign obs_c = {rcc_osc_irq, rdyf[0], hsecss_fail, hse_rdy, hse_en, csi_rdy, csi_en, hsi_rdy, hsi_en};
`else
  assign obs_c = {2'b00, hsecss_fail, hse_rdy, hse_en, csi_rdy, csi_en, hsi_rdy, hsi_en};
`endif

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic string sig_name(input int s);
    case (s)
      S_HSI_EN:  return "hsi_en";
      S_HSI_RDY: return "hsi_rdy";
      S_CSI_EN:  return "csi_en";
      S_CSI_RDY: return "csi_rdy";
      S_HSE_EN:  return "hse_en";
      S_HSE_RDY: return "hse_rdy";
      S_FAIL:    return "hsecss_fail";
      S_RDYF0:   return "rdyf0";
      default:   return "rcc_osc_irq";
    endcase
  endfunction

  // Compare every queued expectation that falls due in the current cycle.
  always @(negedge sys_clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check($sformatf("%s@%0d", sig_name(sb[i].sig), cyc), 32'(obs_c[sb[i].sig]), 32'(sb[i].val));
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        check($sformatf("sb_stale_%s", sig_name(sb[i].sig)), 32'(cyc), 32'(sb[i].cyc));
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge sys_clk);
    #1;
  endtask

  task automatic expect_at(input int c, input int s, input logic v);
    exp_t e;
    e.cyc = c;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic expect_edge(input int c, input int s, input logic v);
    expect_at(c - 1, s, ~v);
    expect_at(c, s, v);
  endtask

  initial begin
    int n, m, p, v, c, x, y, s, k, t, r, w;
    sys_rst = 1'b1;
    hsion = 1'b0; csion = 1'b0; hseon = 1'b0;
    sys_clk_sw = 2'b00;
    rcc_sys_stop = 1'b0;
    hsi_ker_clk_req = 1'b0; csi_ker_clk_req = 1'b0;
    hse_css_evt = 1'b0; hsecss_clr = 1'b0;
`ifdef RCC_OSC_RDY_IRQ_EN
    rdyie = 3'b001;
    rdyc  = 3'b000;
`endif

    // Reset state, then HSI auto-start as the selected system clock.
    tick(3);
    for (int i = 0; i <= S_FAIL; i++) expect_at(cyc, i, 1'b0);
`ifdef RCC_OSC_RDY_IRQ_EN
    expect_at(cyc, S_RDYF0, 1'b0);
    expect_at(cyc, S_IRQ, 1'b0);
`endif
    sys_rst = 1'b0;
    n = cyc + 1;
    expect_edge(n, S_HSI_EN, 1'b1);
    expect_edge(n + 64, S_HSI_RDY, 1'b1);
    expect_at(n + 64, S_CSI_EN, 1'b0);
    expect_at(n + 64, S_CSI_RDY, 1'b0);
    expect_at(n + 64, S_HSE_EN, 1'b0);
    expect_at(n + 64, S_HSE_RDY, 1'b0);
`ifdef RCC_OSC_RDY_IRQ_EN
    expect_edge(n + 65, S_RDYF0, 1'b1);
    expect_edge(n + 66, S_IRQ, 1'b1);
`endif
    tick(70);
`ifdef RCC_OSC_RDY_IRQ_EN
    rdyc = 3'b001;
    p = cyc + 1;
    expect_edge(p, S_RDYF0, 1'b0);
    expect_edge(p + 1, S_IRQ, 1'b0);
    tick(1);
    rdyc = 3'b000;
    tick(3);
`endif

    // HSI shutdown with a re-request that must wait for OFF.
    sys_clk_sw = 2'b11;
    m = cyc + 1;
    expect_edge(m, S_HSI_EN, 1'b0);
    expect_edge(m + 4, S_HSI_RDY, 1'b0);
    tick(2);
    hsion = 1'b1;
    expect_at(m + 3, S_HSI_EN, 1'b0);
    expect_at(m + 4, S_HSI_EN, 1'b0);
    expect_edge(m + 5, S_HSI_EN, 1'b1);
    expect_edge(m + 69, S_HSI_RDY, 1'b1);
    tick(75);

    // HSE startup aborted at cycle 100, then a full restart.
    hseon = 1'b1;
    n = cyc + 1;
    expect_edge(n, S_HSE_EN, 1'b1);
    tick(100);
    hseon = 1'b0;
    expect_edge(n + 100, S_HSE_EN, 1'b0);
    expect_at(n + 101, S_HSE_RDY, 1'b0);
    expect_at(n + 110, S_HSE_EN, 1'b0);
    expect_at(n + 110, S_HSE_RDY, 1'b0);
    tick(20);
    hseon = 1'b1;
    p = cyc + 1;
    expect_edge(p, S_HSE_EN, 1'b1);
    expect_edge(p + 2048, S_HSE_RDY, 1'b1);
    tick(2060);

    // CSS event from RDY, masking, clear, and event+clear collision.
    hse_css_evt = 1'b1;
    v = cyc + 1;
    expect_edge(v, S_HSE_EN, 1'b0);
    expect_edge(v, S_HSE_RDY, 1'b0);
    expect_edge(v, S_FAIL, 1'b1);
    tick(1);
    hse_css_evt = 1'b0;
    expect_at(v + 10, S_HSE_EN, 1'b0);
    expect_at(v + 10, S_FAIL, 1'b1);
    tick(15);
    hsecss_clr = 1'b1;
    c = cyc + 1;
    expect_edge(c, S_FAIL, 1'b0);
    expect_edge(c + 1, S_HSE_EN, 1'b1);
    tick(1);
    hsecss_clr = 1'b0;
    tick(20);
    hse_css_evt = 1'b1;
    hsecss_clr  = 1'b1;
    x = cyc + 1;
    expect_edge(x, S_FAIL, 1'b1);
    expect_edge(x, S_HSE_EN, 1'b0);
    tick(1);
    hse_css_evt = 1'b0;
    hsecss_clr  = 1'b0;
    expect_at(x + 5, S_FAIL, 1'b1);
    expect_at(x + 5, S_HSE_EN, 1'b0);
    tick(10);
    hsecss_clr = 1'b1;
    y = cyc + 1;
    expect_edge(y, S_FAIL, 1'b0);
    expect_edge(y + 1, S_HSE_EN, 1'b1);
    expect_edge(y + 1 + 2048, S_HSE_RDY, 1'b1);
    tick(1);
    hsecss_clr = 1'b0;
    tick(2060);

    // CSI held through stop by its kernel request; HSI and HSE shut down.
    csion = 1'b1;
    n = cyc + 1;
    expect_edge(n, S_CSI_EN, 1'b1);
    expect_edge(n + 32, S_CSI_RDY, 1'b1);
    tick(40);
    rcc_sys_stop = 1'b1;
    csi_ker_clk_req = 1'b1;
    s = cyc + 1;
    expect_at(s + 5, S_CSI_RDY, 1'b1);
    expect_at(s + 5, S_CSI_EN, 1'b1);
    expect_edge(s, S_HSI_EN, 1'b0);
    expect_edge(s + 4, S_HSI_RDY, 1'b0);
    expect_edge(s, S_HSE_EN, 1'b0);
    expect_edge(s + 4, S_HSE_RDY, 1'b0);
    tick(10);
    csi_ker_clk_req = 1'b0;
    k = cyc + 1;
    expect_edge(k, S_CSI_EN, 1'b0);
    expect_edge(k + 4, S_CSI_RDY, 1'b0);
    tick(10);

    // Leave stop, then reset mid-startup clears everything on the next edge.
    rcc_sys_stop = 1'b0;
    t = cyc + 1;
    expect_edge(t, S_HSI_EN, 1'b1);
    expect_edge(t, S_CSI_EN, 1'b1);
    expect_edge(t, S_HSE_EN, 1'b1);
    tick(20);
    sys_rst = 1'b1;
    r = cyc + 1;
    expect_edge(r, S_HSI_EN, 1'b0);
    expect_edge(r, S_CSI_EN, 1'b0);
    expect_edge(r, S_HSE_EN, 1'b0);
    expect_at(r, S_HSI_RDY, 1'b0);
    expect_at(r, S_HSE_RDY, 1'b0);
    tick(3);
    hsion = 1'b0; csion = 1'b0; hseon = 1'b0;
    sys_clk_sw = 2'b01;
    sys_rst = 1'b0;
    n = cyc + 1;
    expect_edge(n, S_CSI_EN, 1'b1);
    expect_at(n, S_HSI_EN, 1'b0);
    expect_at(n, S_HSE_EN, 1'b0);
    tick(5);

    w = 0;
    while (sb.size() > 0 && w < 5000) begin
      tick(1);
      w++;
    end
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
